rtc_bus_scheduler: RTL and testbench

- Owns the parallel multiplexed address/data bus of the RTC chip.
- Shares that bus between three requester state machines: init, write and read. Fixed priority is init > write > read.
- Sequences each granted requester one transaction at a time using three one-cycle strobes: dir_stb (address phase), dat_stb (data phase) and adv_stb (advance state).
- Generates the periodic `lectura` start pulse that triggers a read sweep.

---
 rtl/rtc_bus_pkg.sv | 35 +++
 rtl/rtc_bus_phase_timer.sv | 28 ++
 rtl/rtc_bus_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus scheduler.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_REQ,
        S_A_WAIT,
        S_A_LOW,
        S_A_HIGH,
        S_D_LOW,
        S_D_HIGH,
        S_D_STB,
        S_ADV,
        S_CHECK
    } state_t;

    localparam int unsigned GRANT_W = 3;
    localparam int unsigned BYTE_W  = 8;

    localparam int unsigned G_INIT  = 0;
    localparam int unsigned G_WRITE = 1;
    localparam int unsigned G_READ  = 2;

    localparam logic [BYTE_W-1:0] CMD_CLK_TO_RAM   = 8'hF1;
    localparam logic [BYTE_W-1:0] CMD_TIMER_TO_RAM = 8'hF2;
    localparam logic [BYTE_W-1:0] CMD_DAY          = 8'h24;
    localparam logic [BYTE_W-1:0] CMD_MONTH        = 8'h25;
    localparam logic [BYTE_W-1:0] CMD_YEAR         = 8'h26;

    // States timed by the phase timer.
    function automatic logic is_phase(input state_t s);
        return (s == S_A_LOW) || (s == S_A_HIGH) || (s == S_D_LOW) || (s == S_D_HIGH);
    endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Loadable down-counter timing one PHASE_CYC bus half-phase; last marks its final cycle.
module rtc_bus_phase_timer #(
    parameter int unsigned PHASE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic last
);

    localparam int unsigned CNT_W = (PHASE_CYC > 2) ? $clog2(PHASE_CYC) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            last <= 1'b0;
        end else if (load) begin
            cnt  <= CNT_W'(PHASE_CYC - 1);
            last <= 1'b0;
        end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            last <= (cnt == CNT_W'(1));
        end
    end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the RTC address/data bus between init, write and read requesters
// and issues the periodic read-sweep trigger.
module rtc_bus_scheduler #(
    parameter int unsigned PHASE_CYC   = 4,
    parameter int unsigned REFRESH_CYC = 1000000,
    parameter int unsigned MAX_TXN     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_init,
    input  logic       req_write,
    input  logic       req_read,
    input  logic       done_init,
    input  logic       done_write,
    input  logic       done_read,
    input  logic [7:0] dir_init,
    input  logic [7:0] dir_write,
    input  logic [7:0] dir_read,
    input  logic [7:0] dat_init,
    input  logic [7:0] dat_write,
    input  logic [7:0] ad_in,
    output logic [2:0] grant,
    output logic       dir_stb,
    output logic       dat_stb,
    output logic       adv_stb,
    output logic       lectura,
    output logic [7:0] rd_data,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       busy
);
    import rtc_bus_pkg::*;

    localparam int unsigned REF_W = (REFRESH_CYC > 2) ? $clog2(REFRESH_CYC) : 1;
    localparam int unsigned TXN_W = $clog2(MAX_TXN + 1);

    state_t              state, state_d;
    logic                wait_q, wait_d;
    logic [TXN_W-1:0]    txn_cnt, txn_d;
    logic [BYTE_W-1:0]   addr_reg, addr_d, dat_reg, dat_d;
    logic [REF_W-1:0]    refresh_cnt;
    logic                pending, pending_d, wrap, pend_now, fire;
    logic                timer_load, phase_last;
    logic                is_read, done_sel;
    logic [BYTE_W-1:0]   dir_sel, dat_sel;
    logic [GRANT_W-1:0]  grant_d;
    logic                busy_d, dir_stb_d, dat_stb_d, adv_stb_d, lectura_d;
    logic [BYTE_W-1:0]   rd_data_d, ad_out_d;
    logic                ad_oe_d, cs_n_d, rd_n_d, wr_n_d, a_d_d;

    rtc_bus_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .last  (phase_last)
    );

    assign is_read  = grant[G_READ];
    assign dir_sel  = grant[G_READ] ? dir_read : (grant[G_WRITE] ? dir_write : dir_init);
    assign dat_sel  = grant[G_WRITE] ? dat_write : dat_init;
    assign done_sel = (grant[G_INIT] & done_init) | (grant[G_WRITE] & done_write)
                    | (grant[G_READ] & done_read);
    assign wrap     = (refresh_cnt == REF_W'(REFRESH_CYC - 1));

    // Next state, datapath latches and registered-output decode of the next state.
    always_comb begin
        state_d   = state;
        wait_d    = 1'b0;
        txn_d     = txn_cnt;
        addr_d    = addr_reg;
        dat_d     = dat_reg;
        grant_d   = grant;
        rd_data_d = rd_data;
        ad_out_d  = ad_out;
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        a_d_d     = 1'b1;
        ad_oe_d   = 1'b0;
        dir_stb_d = 1'b0;
        dat_stb_d = 1'b0;
        adv_stb_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_init || req_write || req_read) begin
                    grant_d = '0;
                    state_d = S_A_REQ;
                    if (req_init)       grant_d[G_INIT]  = 1'b1;
                    else if (req_write) grant_d[G_WRITE] = 1'b1;
                    else                grant_d[G_READ]  = 1'b1;
                end
            end
            S_A_REQ:  state_d = S_A_WAIT;
            S_A_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    addr_d  = dir_sel;
                    state_d = S_A_LOW;
                end
            end
            S_A_LOW:  if (phase_last) state_d = S_A_HIGH;
            S_A_HIGH: begin
                if (phase_last) begin
                    dat_d   = dat_sel;
                    state_d = S_D_LOW;
                end
            end
            S_D_LOW: begin
                if (phase_last) begin
                    if (is_read) rd_data_d = ad_in;
                    state_d = S_D_HIGH;
                end
            end
            S_D_HIGH: if (phase_last) state_d = S_D_STB;
            S_D_STB:  state_d = S_ADV;
            S_ADV: begin
                txn_d   = txn_cnt + TXN_W'(1);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (done_sel || (txn_cnt == TXN_W'(MAX_TXN))) begin
                    grant_d = '0;
                    txn_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_A_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        timer_load = is_phase(state_d) && (state_d != state);
        busy_d     = (grant_d != '0);

        case (state_d)
            S_A_REQ: dir_stb_d = 1'b1;
            S_A_LOW: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            S_A_HIGH: begin
                cs_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            S_D_LOW: begin
                cs_n_d = 1'b0;
                if (is_read) begin
                    rd_n_d = 1'b0;
                end else begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = dat_d;
                end
            end
            S_D_HIGH: begin
                // Write data stays driven for hold; cs_n rises only on the following cycle.
                cs_n_d = 1'b0;
                if (!is_read) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = dat_d;
                end
            end
            S_D_STB: dat_stb_d = 1'b1;
            S_ADV:   adv_stb_d = 1'b1;
            default: ;
        endcase

        // Pending refresh fires on any idle cycle not claimed by init or write.
        pend_now  = pending | wrap;
        fire      = pend_now && !req_init && !req_write
                    && ((state == S_IDLE) || (state_d == S_IDLE));
        lectura_d = fire;
        pending_d = fire ? 1'b0 : pend_now;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_q      <= 1'b0;
            txn_cnt     <= '0;
            addr_reg    <= '0;
            dat_reg     <= '0;
            refresh_cnt <= '0;
            pending     <= 1'b0;
            grant       <= '0;
            busy        <= 1'b0;
            dir_stb     <= 1'b0;
            dat_stb     <= 1'b0;
            adv_stb     <= 1'b0;
            lectura     <= 1'b0;
            rd_data     <= '0;
            ad_out      <= '0;
            ad_oe       <= 1'b0;
            cs_n        <= 1'b1;
            rd_n        <= 1'b1;
            wr_n        <= 1'b1;
            a_d         <= 1'b1;
        end else begin
            state       <= state_d;
            wait_q      <= wait_d;
            txn_cnt     <= txn_d;
            addr_reg    <= addr_d;
            dat_reg     <= dat_d;
            refresh_cnt <= wrap ? '0 : refresh_cnt + REF_W'(1);
            pending     <= pending_d;
            grant       <= grant_d;
            busy        <= busy_d;
            dir_stb     <= dir_stb_d;
            dat_stb     <= dat_stb_d;
            adv_stb     <= adv_stb_d;
            lectura     <= lectura_d;
            rd_data     <= rd_data_d;
            ad_out      <= ad_out_d;
            ad_oe       <= ad_oe_d;
            cs_n        <= cs_n_d;
            rd_n        <= rd_n_d;
            wr_n        <= wr_n_d;
            a_d         <= a_d_d;
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed bench for rtc_bus_scheduler: transaction vector table plus priority,
// watchdog/refresh and mid-transaction reset sequences.
module tb_rtc_bus_scheduler;
    import rtc_bus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_init, req_write, req_read;
    logic       done_init, done_write, done_read;
    logic [7:0] dir_init, dir_write, dir_read, dat_init, dat_write, ad_in;
    logic [2:0] grant;
    logic       dir_stb, dat_stb, adv_stb, lectura;
    logic [7:0] rd_data, ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy;

    int n_applied = 0;
    int n_miss    = 0;

    rtc_bus_scheduler #(.PHASE_CYC(4), .REFRESH_CYC(50), .MAX_TXN(16)) dut (
        .clk(clk), .reset(reset),
        .req_init(req_init), .req_write(req_write), .req_read(req_read),
        .done_init(done_init), .done_write(done_write), .done_read(done_read),
        .dir_init(dir_init), .dir_write(dir_write), .dir_read(dir_read),
        .dat_init(dat_init), .dat_write(dat_write), .ad_in(ad_in),
        .grant(grant), .dir_stb(dir_stb), .dat_stb(dat_stb), .adv_stb(adv_stb),
        .lectura(lectura), .rd_data(rd_data), .ad_out(ad_out), .ad_oe(ad_oe),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;        // {read, write, init}
        logic [7:0] dir_i, dir_w, dir_r, dat_i, dat_w, rd_val;
        logic [2:0] exp_grant;
        logic [7:0] exp_addr, exp_wdata;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   busy_len = 0, n_dir = 0, n_dat = 0, n_adv = 0, n_alow = 0, n_ahigh = 0;
        int   n_dwr = 0, n_drd = 0, bad_grant = 0, cs_bad = 0, stray = 0;
        logic [7:0] rd_at_stb = 8'h00;
        logic prev_cs = 1'b1, prev_rd = 1'b1, prev_wr = 1'b1;
        bit   seen = 0, fin = 0;
        bit   is_rd = v.exp_grant[G_READ];
        {req_read, req_write, req_init} = v.req;
        dir_init = v.dir_i; dir_write = v.dir_w; dir_read = v.dir_r;
        dat_init = v.dat_i; dat_write = v.dat_w;
        done_init = 1'b1; done_write = 1'b1; done_read = 1'b1;
        ad_in = 8'hEE;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (grant != 3'b000) begin
                seen = 1;
                busy_len++;
                {req_read, req_write, req_init} = 3'b000;
                if (grant !== v.exp_grant) bad_grant++;
                if (dir_stb) n_dir++;
                if (dat_stb) begin n_dat++; rd_at_stb = rd_data; end
                if (adv_stb) n_adv++;
                if (!cs_n && ad_oe && !a_d && !wr_n && ad_out == v.exp_addr) n_alow++;
                if (!cs_n && ad_oe && !a_d && wr_n && ad_out == v.exp_addr) n_ahigh++;
                if (!cs_n && ad_oe && a_d && !wr_n && rd_n && ad_out == v.exp_wdata) n_dwr++;
                if (!cs_n && !ad_oe && a_d && !rd_n && wr_n) n_drd++;
            end else begin
                if (dir_stb || dat_stb || adv_stb) stray++;
                if (seen) fin = 1;
            end
            if (cs_n && !prev_cs && !(prev_rd && prev_wr)) cs_bad++;
            prev_cs = cs_n; prev_rd = rd_n; prev_wr = wr_n;
            // ad_in carries the read value only while rd_n is low
            ad_in = rd_n ? 8'hEE : v.rd_val;
        end
        check($sformatf("v%0d busy_len", idx), 32'(busy_len), 32'd23);
        check($sformatf("v%0d grant", idx), 32'(bad_grant), 32'd0);
        check($sformatf("v%0d dir_stb", idx), 32'(n_dir), 32'd1);
        check($sformatf("v%0d dat_stb", idx), 32'(n_dat), 32'd1);
        check($sformatf("v%0d adv_stb", idx), 32'(n_adv), 32'd1);
        check($sformatf("v%0d addr_low", idx), 32'(n_alow), 32'd4);
        check($sformatf("v%0d addr_high", idx), 32'(n_ahigh), 32'd4);
        check($sformatf("v%0d data_write", idx), 32'(n_dwr), is_rd ? 32'd0 : 32'd4);
        check($sformatf("v%0d data_read", idx), 32'(n_drd), is_rd ? 32'd4 : 32'd0);
        check($sformatf("v%0d cs_order", idx), 32'(cs_bad), 32'd0);
        check($sformatf("v%0d stray_stb", idx), 32'(stray), 32'd0);
        if (is_rd) check($sformatf("v%0d rd_data", idx), 32'(rd_at_stb), 32'(v.rd_val));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n, n_adv, busy_len, lect_busy, stray;
        bit hit;
        vecs[0] = '{3'b010, CMD_CLK_TO_RAM, 8'h21, CMD_DAY, 8'h5A, 8'h45, 8'h00, 3'b010, 8'h21, 8'h45};
        vecs[1] = '{3'b100, CMD_CLK_TO_RAM, 8'h21, CMD_DAY, 8'h5A, 8'h45, 8'h37, 3'b100, 8'h24, 8'h00};
        vecs[2] = '{3'b001, CMD_CLK_TO_RAM, 8'h21, CMD_DAY, 8'h3C, 8'h45, 8'h00, 3'b001, 8'hF1, 8'h3C};
        vecs[3] = '{3'b011, CMD_TIMER_TO_RAM, CMD_MONTH, CMD_YEAR, 8'h81, 8'h99, 8'h00, 3'b001, 8'hF2, 8'h81};
        vecs[4] = '{3'b110, CMD_TIMER_TO_RAM, CMD_YEAR, CMD_MONTH, 8'h81, 8'h07, 8'h00, 3'b010, 8'h26, 8'h07};
        vecs[5] = '{3'b111, CMD_CLK_TO_RAM, CMD_MONTH, CMD_DAY, 8'hC3, 8'h99, 8'h00, 3'b001, 8'hF1, 8'hC3};
        vecs[6] = '{3'b100, CMD_CLK_TO_RAM, CMD_MONTH, CMD_YEAR, 8'hC3, 8'h99, 8'hA5, 3'b100, 8'h26, 8'h00};

        reset = 1'b1;
        {req_init, req_write, req_read} = 3'b000;
        {done_init, done_write, done_read} = 3'b111;
        dir_init = 8'h00; dir_write = 8'h00; dir_read = 8'h00;
        dat_init = 8'h00; dat_write = 8'h00; ad_in = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'({grant, dir_stb, dat_stb, adv_stb, lectura, rd_data, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, busy}),
              32'({3'b000, 4'b0000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Init and read arrive together: init first, read right after.
        dir_init = CMD_CLK_TO_RAM; dir_read = CMD_DAY;
        req_init = 1'b1; req_read = 1'b1;
        hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (grant != 3'b000) hit = 1;
        end
        check("prio_first_grant", 32'(grant), 32'(3'b001));
        req_init = 1'b0;
        n = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (grant == 3'b001) n++;
            else break;
        end
        check("prio_init_len", 32'(n), 32'd23);
        check("prio_gap", 32'(grant), 32'(3'b000));
        @(negedge clk);
        check("prio_read_next", 32'(grant), 32'(3'b100));
        req_read = 1'b0;
        for (int c = 0; c < 40 && grant != 3'b000; c++) @(negedge clk);
        repeat (3) @(negedge clk);

        // Read that never finishes: watchdog release, refresh wraps merged while busy.
        done_read = 1'b0;
        req_read  = 1'b1;
        hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (grant != 3'b000) hit = 1;
        end
        req_read = 1'b0;
        busy_len = 1; n_adv = 0; lect_busy = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (grant == 3'b000) break;
            busy_len++;
            if (adv_stb) n_adv++;
            if (lectura && busy_len >= 2) lect_busy++;
        end
        check("wd_busy_len", 32'(busy_len), 32'd368);
        check("wd_adv_count", 32'(n_adv), 32'd16);
        check("refresh_busy_pulses", 32'(lect_busy), 32'd0);
        check("refresh_first_idle", 32'(lectura), 32'd1);
        done_read = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during the data-low window of a write.
        dir_write = CMD_YEAR; dat_write = 8'h19; req_write = 1'b1;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (!cs_n && a_d && !wr_n) hit = 1;
        end
        check("rst_reached_dlow", 32'(hit), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_bus_release", 32'({cs_n, wr_n, rd_n, ad_oe, grant, busy}),
              32'({1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0}));
        req_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dir_stb || dat_stb || adv_stb || grant != 3'b000) stray++;
        end
        check("rst_quiet_after", 32'(stray), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
